// File: rtl/sdram_aref.sv
// sdram_aref - SDRAM auto-refresh requester.
//
// Once SDRAM initialization has completed, a free-running interval timer asks
// the arbiter for the bus every REF_CYCLES clocks. When the arbiter grants the
// request, the block issues a PRECHARGE-ALL and then AREF_NUM AUTO REFRESH
// commands with TRP / TRFC spacing. It then pulses aref_done so the arbiter
// can release the bus.
//
// Ports:
//   sclk        in   system clock, rising edge
//   srst_n      in   asynchronous active-low reset
//   init_end    in   SDRAM init complete (latched, sticky until reset)
//   aref_ack    in   arbiter grant (level; honoured only in IDLE with a pending request)
//   aref_req    out  refresh request to the arbiter
//   aref_done   out  one-cycle pulse at the end of the refresh sequence
//   aref_cmd    out  {CS_n, RAS_n, CAS_n, WE_n}
//   aref_addr   out  SDRAM address (A10 high during PRECHARGE-ALL)
//   ref_overrun out  sticky: an interval expired while a request was still pending
module sdram_aref #(
    parameter int REF_CYCLES = 750,
    parameter int TRP        = 2,
    parameter int TRFC       = 7,
    parameter int AREF_NUM   = 2
) (
    input  logic        sclk,
    input  logic        srst_n,
    input  logic        init_end,
    input  logic        aref_ack,
    output logic        aref_req,
    output logic        aref_done,
    output logic [3:0]  aref_cmd,
    output logic [12:0] aref_addr,
    output logic        ref_overrun
);

    localparam int TW   = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam int CW   = $clog2(AREF_NUM + 1);
    localparam int WMAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(REF_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE      = TW'(1'b1);
    localparam logic [WW-1:0] W_ONE      = WW'(1'b1);
    localparam logic [CW-1:0] C_ONE      = CW'(1'b1);
    localparam logic [CW-1:0] AREF_TOTAL = CW'(AREF_NUM);
    // Last count value of each wait state (the state is skipped when its spacing is 1).
    localparam logic [WW-1:0] RP_LAST    = WW'((TRP > 1) ? TRP - 2 : 0);
    localparam logic [WW-1:0] RFC_LAST   = WW'((TRFC > 1) ? TRFC - 2 : 0);

    localparam logic [3:0]  CMD_NOP   = 4'b0111;
    localparam logic [3:0]  CMD_PRE   = 4'b0010;
    localparam logic [3:0]  CMD_AREF  = 4'b0001;
    localparam logic [12:0] ADDR_PALL = 13'h0400;
    localparam logic [12:0] ADDR_ZERO = 13'h0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_WAIT_RP  = 3'd2,
        ST_AREF     = 3'd3,
        ST_WAIT_RFC = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    logic            init_r;
    logic [TW-1:0]   timer_r;
    state_t          state_r;
    state_t          state_s;
    logic [WW-1:0]   wait_cnt_r;
    logic [WW-1:0]   wait_cnt_s;
    logic [CW-1:0]   aref_cnt_r;
    logic [CW-1:0]   aref_cnt_s;
    logic            expire_s;
    logic            accept_s;
    logic            req_s;
    logic            ovr_s;
    logic [3:0]      cmd_s;
    logic [12:0]     addr_s;
    logic            done_s;
    logic            aref_req_r;
    logic            aref_done_r;
    logic [3:0]      aref_cmd_r;
    logic [12:0]     aref_addr_r;
    logic            ref_overrun_r;

    assign aref_req    = aref_req_r;
    assign aref_done   = aref_done_r;
    assign aref_cmd    = aref_cmd_r;
    assign aref_addr   = aref_addr_r;
    assign ref_overrun = ref_overrun_r;

    // Interval expiry, grant acceptance, and next request / overrun flags.
    always_comb begin
        expire_s = init_r && (timer_r == TIMER_LAST);
        accept_s = aref_ack && aref_req_r && (state_r == ST_IDLE);
        // An expiry in the accept cycle is a fresh interval, so it wins over the clear.
        if (expire_s) begin
            req_s = 1'b1;
        end else if (accept_s) begin
            req_s = 1'b0;
        end else begin
            req_s = aref_req_r;
        end
        ovr_s = ref_overrun_r | (expire_s & aref_req_r & ~accept_s);
    end

    // Init latch and refresh interval timer (runs through sequences too).
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            init_r  <= 1'b0;
            timer_r <= {TW{1'b0}};
        end else begin
            init_r <= init_r | init_end;
            if (!init_r) begin
                timer_r <= {TW{1'b0}};
            end else if (timer_r == TIMER_LAST) begin
                timer_r <= {TW{1'b0}};
            end else begin
                timer_r <= timer_r + T_ONE;
            end
        end
    end

    // Sequence FSM next state plus wait and AREF counters.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = {WW{1'b0}};
        aref_cnt_s = aref_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_PRE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (TRP > 1) begin
                    state_s = ST_WAIT_RP;
                end else begin
                    state_s = ST_AREF;
                end
            end
            ST_WAIT_RP: begin
                if (wait_cnt_r == RP_LAST) begin
                    state_s = ST_AREF;
                end else begin
                    state_s    = ST_WAIT_RP;
                    wait_cnt_s = wait_cnt_r + W_ONE;
                end
            end
            ST_AREF: begin
                aref_cnt_s = aref_cnt_r + C_ONE;
                // With TRFC of 1 the decision is taken here, on the updated count.
                if (TRFC > 1) begin
                    state_s = ST_WAIT_RFC;
                end else if (aref_cnt_s < AREF_TOTAL) begin
                    state_s = ST_AREF;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_WAIT_RFC: begin
                if (wait_cnt_r != RFC_LAST) begin
                    state_s    = ST_WAIT_RFC;
                    wait_cnt_s = wait_cnt_r + W_ONE;
                end else if (aref_cnt_r < AREF_TOTAL) begin
                    state_s = ST_AREF;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s    = ST_IDLE;
                aref_cnt_s = {CW{1'b0}};
            end
            default: begin
                state_s    = ST_IDLE;
                aref_cnt_s = {CW{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with the state.
    always_comb begin
        cmd_s  = CMD_NOP;
        addr_s = ADDR_ZERO;
        done_s = 1'b0;
        case (state_s)
            ST_PRE: begin
                cmd_s  = CMD_PRE;
                addr_s = ADDR_PALL;
            end
            ST_AREF: begin
                cmd_s  = CMD_AREF;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                cmd_s  = CMD_NOP;
                addr_s = ADDR_ZERO;
                done_s = 1'b0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WW{1'b0}};
            aref_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            aref_cnt_r <= aref_cnt_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            aref_req_r    <= 1'b0;
            aref_done_r   <= 1'b0;
            aref_cmd_r    <= CMD_NOP;
            aref_addr_r   <= ADDR_ZERO;
            ref_overrun_r <= 1'b0;
        end else begin
            aref_req_r    <= req_s;
            aref_done_r   <= done_s;
            aref_cmd_r    <= cmd_s;
            aref_addr_r   <= addr_s;
            ref_overrun_r <= ovr_s;
        end
    end

endmodule

// File: tb/tb_sdram_aref.sv
// tb_sdram_aref - self-checking bench for sdram_aref.
// A behavioural model tracks the interval age since the init latch, the
// pending request and the start cycle of the running sequence. The expected
// command on any cycle is derived arithmetically from its offset to the
// accept cycle.
module tb_sdram_aref;

    localparam int REF   = 40;
    localparam int TRP   = 2;
    localparam int TRFC  = 7;
    localparam int NAREF = 2;
    localparam int SEQ   = 1 + TRP + NAREF * TRFC;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    logic        sclk = 1'b0;
    logic        srst_n;
    logic        init_end;
    logic        aref_ack;
    logic        aref_req;
    logic        aref_done;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        ref_overrun;

    sdram_aref #(.REF_CYCLES(REF), .TRP(TRP), .TRFC(TRFC), .AREF_NUM(NAREF)) dut (
        .sclk        (sclk),
        .srst_n      (srst_n),
        .init_end    (init_end),
        .aref_ack    (aref_ack),
        .aref_req    (aref_req),
        .aref_done   (aref_done),
        .aref_cmd    (aref_cmd),
        .aref_addr   (aref_addr),
        .ref_overrun (ref_overrun)
    );

    always #5 sclk = ~sclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    bit          m_init, m_req, m_ovr, m_active;
    int          m_age, m_cyc, m_t0;
    logic [3:0]  e_cmd;
    logic [12:0] e_addr;
    logic        e_done;

    function automatic void model_reset();
        m_init = 1'b0; m_req = 1'b0; m_ovr = 1'b0; m_active = 1'b0;
        m_age = 0; m_t0 = 0;
        e_cmd = NOP; e_addr = 13'h0000; e_done = 1'b0;
    endfunction

    function automatic bit model_busy();
        return m_active && (m_cyc - m_t0) >= 1 && (m_cyc - m_t0) <= SEQ;
    endfunction

    // Advance the model across one rising edge using the inputs of the ending cycle.
    function automatic void model_step();
        bit expiry, accept;
        int d;
        if (!srst_n) begin
            model_reset();
            m_cyc++;
            return;
        end
        expiry = m_init && (m_age % REF == REF - 1);
        accept = aref_ack && m_req && !model_busy();
        if (m_init) m_age++;
        else if (init_end) begin m_init = 1'b1; m_age = 0; end
        if (expiry && m_req && !accept) m_ovr = 1'b1;
        if (expiry) m_req = 1'b1;
        else if (accept) m_req = 1'b0;
        if (accept) begin m_active = 1'b1; m_t0 = m_cyc; end
        m_cyc++;
        d = m_cyc - m_t0;
        e_cmd = NOP; e_addr = 13'h0000; e_done = 1'b0;
        if (m_active) begin
            if (d == 1) begin
                e_cmd = PRE; e_addr = 13'h0400;
            end else if (d >= 1 + TRP && d <= 1 + TRP + (NAREF - 1) * TRFC && (d - 1 - TRP) % TRFC == 0) begin
                e_cmd = AREF;
            end else if (d == SEQ) begin
                e_done = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge sclk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        srst_n = 1'b0; init_end = 1'b0; aref_ack = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (aref_req !== 1'b0 || aref_done !== 1'b0 || ref_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got req=%b done=%b ovr=%b want 0 0 0", aref_req, aref_done, ref_overrun);
        end
        n_cmp++;
        if (aref_cmd !== NOP || aref_addr !== 13'h0000) begin
            n_fail++;
            $display("FAIL reset_cmd got cmd=%b addr=%h want cmd=%b addr=0000", aref_cmd, aref_addr, NOP);
        end
        srst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if (aref_req !== 1'b0 || aref_cmd !== NOP || aref_done !== 1'b0) begin
                n_fail++;
                $display("FAIL pre_init cyc=%0d got req=%b cmd=%b done=%b want 0 %b 0", i, aref_req, aref_cmd, aref_done, NOP);
            end
        end
        init_end = 1'b1;
        tick();
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (aref_req !== 1'b1 && cnt < 60);
        n_cmp++;
        if (cnt != REF) begin
            n_fail++;
            $display("FAIL first_req_latency got %0d cycles want %0d", cnt, REF);
        end
    endtask

    task automatic test_full_sequence();
        int dly, t_pre, t_done, n_done;
        int arefs[$];
        t_pre = -1; t_done = -1; n_done = 0;
        for (int i = 0; i < 2 * REF && !m_req; i++) tick();
        n_cmp++;
        if (aref_req !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_req_wait got req=%b want 1", aref_req);
        end
        dly = $urandom_range(0, 8);
        repeat (dly) tick();
        aref_ack = 1'b1;
        for (int i = 1; i <= SEQ + 3; i++) begin
            if (i == 2) aref_ack = 1'b0;
            tick();
            n_cmp++;
            if (aref_cmd !== e_cmd || aref_addr !== e_addr || aref_done !== e_done || aref_req !== m_req) begin
                n_fail++;
                $display("FAIL seq_cycle t0+%0d got cmd=%b addr=%h done=%b req=%b want %b %h %b %b",
                         i, aref_cmd, aref_addr, aref_done, aref_req, e_cmd, e_addr, e_done, m_req);
            end
            if (i == 1) begin
                n_cmp++;
                if (aref_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seq_req_fall got req=%b at t0+1 want 0", aref_req);
                end
            end
            if (aref_cmd === PRE && aref_addr === 13'h0400) t_pre = i;
            if (aref_cmd === AREF) arefs.push_back(i);
            if (aref_done === 1'b1) begin n_done++; t_done = i; end
        end
        n_cmp++;
        if (t_pre != 1) begin
            n_fail++;
            $display("FAIL seq_pre_time got t0+%0d want t0+1", t_pre);
        end
        n_cmp++;
        if (arefs.size() != NAREF) begin
            n_fail++;
            $display("FAIL seq_aref_count got %0d want %0d", arefs.size(), NAREF);
        end
        for (int k = 0; k < arefs.size() && k < NAREF; k++) begin
            n_cmp++;
            if (arefs[k] != 1 + TRP + k * TRFC) begin
                n_fail++;
                $display("FAIL seq_aref_time k=%0d got t0+%0d want t0+%0d", k + 1, arefs[k], 1 + TRP + k * TRFC);
            end
        end
        n_cmp++;
        if (n_done != 1 || t_done != SEQ) begin
            n_fail++;
            $display("FAIL seq_done got %0d pulses at t0+%0d want 1 at t0+%0d", n_done, t_done, SEQ);
        end
    endtask

    task automatic test_spurious_ack();
        int n;
        n = $urandom_range(3, 8);
        for (int i = 0; i < n && !m_req; i++) begin
            aref_ack = 1'b1;
            tick();
            n_cmp++;
            if (aref_cmd !== NOP || aref_done !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_ack got cmd=%b done=%b want %b 0", aref_cmd, aref_done, NOP);
            end
        end
        aref_ack = 1'b0;
        repeat (2) begin
            tick();
            n_cmp++;
            if (aref_cmd !== NOP || aref_done !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_after got cmd=%b done=%b want %b 0", aref_cmd, aref_done, NOP);
            end
        end
    endtask

    task automatic test_coincident();
        int n_done;
        n_done = 0;
        for (int i = 0; i < 3 * REF && !(m_req && !model_busy() && m_init && (m_age % REF == REF - 1)); i++) tick();
        n_cmp++;
        if (!(m_req && aref_req === 1'b1)) begin
            n_fail++;
            $display("FAIL coinc_align got req=%b want 1 at the wrap cycle", aref_req);
        end
        aref_ack = 1'b1;
        tick();
        aref_ack = 1'b0;
        for (int i = 1; i <= SEQ + 1; i++) begin
            n_cmp++;
            if (aref_req !== 1'b1 || aref_cmd !== e_cmd || ref_overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL coinc_cycle t0+%0d got req=%b cmd=%b ovr=%b want 1 %b %b", i, aref_req, aref_cmd, ref_overrun, e_cmd, m_ovr);
            end
            if (aref_done === 1'b1) n_done++;
            tick();
        end
        n_cmp++;
        if (n_done != 1 || ref_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_done got %0d pulses ovr=%b want 1 pulse ovr=0", n_done, ref_overrun);
        end
    endtask

    task automatic test_overrun();
        int n_done;
        n_done = 0;
        for (int i = 0; i < 2 * REF + 2 && !m_ovr; i++) begin
            tick();
            n_cmp++;
            if (ref_overrun !== m_ovr || aref_req !== m_req) begin
                n_fail++;
                $display("FAIL ovr_track got ovr=%b req=%b want %b %b", ref_overrun, aref_req, m_ovr, m_req);
            end
        end
        n_cmp++;
        if (ref_overrun !== 1'b1 || aref_req !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set got ovr=%b req=%b want 1 1", ref_overrun, aref_req);
        end
        aref_ack = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) aref_ack = 1'b0;
            tick();
            n_cmp++;
            if (aref_cmd !== e_cmd || aref_done !== e_done || ref_overrun !== 1'b1) begin
                n_fail++;
                $display("FAIL ovr_seq cyc=%0d got cmd=%b done=%b ovr=%b want %b %b 1", i, aref_cmd, aref_done, ref_overrun, e_cmd, e_done);
            end
            if (aref_done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ovr_one_seq got %0d sequences want 1", n_done);
        end
    endtask

    task automatic test_reset_mid();
        int stop, cnt;
        for (int i = 0; i < 2 * REF && !m_req; i++) tick();
        aref_ack = 1'b1;
        tick();
        aref_ack = 1'b0;
        stop = 1 + TRP + 1 + $urandom_range(0, TRFC - 2);
        for (int i = 0; i < SEQ && (m_cyc - m_t0) < stop; i++) tick();
        #2;
        srst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (aref_req !== 1'b0 || aref_done !== 1'b0 || ref_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags got req=%b done=%b ovr=%b want 0 0 0", aref_req, aref_done, ref_overrun);
        end
        n_cmp++;
        if (aref_cmd !== NOP || aref_addr !== 13'h0000) begin
            n_fail++;
            $display("FAIL midrst_cmd got cmd=%b addr=%h want %b 0000", aref_cmd, aref_addr, NOP);
        end
        init_end = 1'b0;
        repeat (3) tick();
        srst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (aref_req !== 1'b0 || aref_cmd !== NOP) begin
                n_fail++;
                $display("FAIL midrst_quiet cyc=%0d got req=%b cmd=%b want 0 %b", i, aref_req, aref_cmd, NOP);
            end
        end
        init_end = 1'b1;
        tick();
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (aref_req !== 1'b1 && cnt < 60);
        n_cmp++;
        if (cnt != REF) begin
            n_fail++;
            $display("FAIL midrst_relatch got %0d cycles want %0d", cnt, REF);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            aref_ack = ($urandom_range(0, 3) == 0);
            init_end = $urandom_range(0, 1);
            tick();
            n_cmp++;
            if (aref_cmd !== e_cmd || aref_addr !== e_addr || aref_done !== e_done ||
                aref_req !== m_req || ref_overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL random cyc=%0d got cmd=%b addr=%h done=%b req=%b ovr=%b want %b %h %b %b %b",
                         i, aref_cmd, aref_addr, aref_done, aref_req, ref_overrun, e_cmd, e_addr, e_done, m_req, m_ovr);
            end
        end
        aref_ack = 1'b0;
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        srst_n = 1'b0; init_end = 1'b0; aref_ack = 1'b0;
        test_reset();
        test_full_sequence();
        test_spurious_ack();
        test_coincident();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
